// File: rtl/acc_requant.sv
// Accumulates len signed products, adds bias, then rounds, shifts and saturates the sum to int8.
// Optional ReLU clamp on the output when ACC_REQUANT_RELU_EN is defined.
module acc_requant #(
  parameter int PW = 16,
  parameter int AW = 24,
  parameter int OW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic [CW-1:0] cfg_len,
  input  logic [3:0]    cfg_shift,
  input  logic [PW-1:0] cfg_bias,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_q,
  output logic          out_sat
);

  localparam int RW = AW + 2;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0] QMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {IDLE, ACC, RQ, OUT} state_t;

  state_t                 state;
  logic signed [AW-1:0]   acc;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          len;
  logic [3:0]             shift;
  logic signed [PW-1:0]   bias;
  logic                   sticky;

  logic signed [AW:0]     acc_sum;
  logic signed [AW-1:0]   acc_next;
  logic                   acc_ovf;
  logic signed [RW-1:0]   rq_sum;
  logic signed [RW-1:0]   rq_rnd;
  logic signed [RW-1:0]   rq_shf;
  logic [OW-1:0]          rq_q;
  logic                   rq_clamp;

  assign in_ready = !sclr && (state == IDLE || state == ACC);

  // One extra bit catches overflow; clamp to the AW-bit extremes.
  always_comb begin
    acc_sum  = {acc[AW-1], acc} + {{(AW+1-PW){in_p[PW-1]}}, in_p};
    acc_ovf  = acc_sum[AW] != acc_sum[AW-1];
    acc_next = acc_sum[AW-1:0];
    if (acc_ovf)
      acc_next = acc_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  end

  // Two guard bits keep bias plus rounding term from wrapping.
  always_comb begin
    rq_sum   = {{2{acc[AW-1]}}, acc} + {{(RW-PW){bias[PW-1]}}, bias};
    rq_rnd   = '0;
    if (shift != 4'd0)
      rq_rnd = {{(RW-1){1'b0}}, 1'b1} << (shift - 4'd1);
    rq_shf   = (rq_sum + rq_rnd) >>> shift;
    rq_clamp = 1'b0;
    rq_q     = rq_shf[OW-1:0];
    if (rq_shf > QMAX) begin
      rq_q     = {1'b0, {(OW-1){1'b1}}};
      rq_clamp = 1'b1;
    end else if (rq_shf < QMIN) begin
      rq_q     = {1'b1, {(OW-1){1'b0}}};
      rq_clamp = 1'b1;
    end
`ifdef ACC_REQUANT_RELU_EN
    if (rq_q[OW-1])
      rq_q = '0;
`endif
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len       <= ONE;
      shift     <= '0;
      bias      <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          len    <= (cfg_len == '0) ? ONE : cfg_len;
          shift  <= cfg_shift;
          bias   <= cfg_bias;
          acc    <= {{(AW-PW){in_p[PW-1]}}, in_p};
          cnt    <= ONE;
          sticky <= 1'b0;
          state  <= (cfg_len == '0 || cfg_len == ONE) ? RQ : ACC;
        end
        ACC: if (in_valid) begin
          acc    <= acc_next;
          sticky <= sticky | acc_ovf;
          cnt    <= cnt + ONE;
          if (cnt + ONE == len)
            state <= RQ;
        end
        RQ: begin
          out_q     <= rq_q;
          out_sat   <= sticky | rq_clamp;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
          cnt       <= '0;
          sticky    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
